// File: rtl/ntt_stage_ctrl.sv
// ntt_stage_ctrl: radix-2 in-place NTT sequencer over Z/65537.
// Issues one butterfly per cycle, delays pairs to write-back, barriers stages.
module ntt_stage_ctrl #(
  parameter int LOGN    = 8,
  parameter int BF_LAT  = 4,
  parameter int STAGE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hold,
  output logic               busy,
  output logic               done,
  output logic [STAGE_W-1:0] stage,
  output logic               rd_en,
  output logic [LOGN-1:0]    rd_addr_a,
  output logic [LOGN-1:0]    rd_addr_b,
  output logic [LOGN-2:0]    tw_idx,
  output logic               wr_en,
  output logic [LOGN-1:0]    wr_addr_a,
  output logic [LOGN-1:0]    wr_addr_b
);

  localparam int NH = 1 << (LOGN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t st_q, st_d;

  logic [STAGE_W-1:0] s_q, s_d;
  logic [LOGN-2:0]    b_q, b_d;

  // Delay line: valid, last-of-stage marker and both addresses per slot.
  // Slot BF_LAT-1 is the oldest and drives the write-back port.
  logic [BF_LAT-1:0]           v_q, v_d;
  logic [BF_LAT-1:0]           l_q, l_d;
  logic [BF_LAT-1:0][LOGN-1:0] wa_q, wa_d;
  logic [BF_LAT-1:0][LOGN-1:0] wb_q, wb_d;

  logic [31:0]     sh;
  logic [LOGN-1:0] bx;
  logic [LOGN-1:0] half;
  logic [LOGN-1:0] lowm;
  logic [LOGN-1:0] ra;
  logic [LOGN-1:0] rb;
  logic [LOGN-2:0] tw;
  logic            issue;
  logic            b_last;
  logic            s_last;
  logic            w_last;

  // Butterfly address and twiddle index for the current (s, b).
  always_comb begin
    sh   = 32'(s_q);
    bx   = LOGN'(b_q);
    half = LOGN'(1) << sh;
    lowm = half - LOGN'(1);
    ra   = ((bx >> sh) << (sh + 32'd1))
         | (bx & lowm);
    rb   = ra + half;
    tw   = (LOGN-1)'((bx & lowm)
         << (32'(LOGN - 1) - sh));
  end

  // Issue qualification and end-of-sequence flags.
  always_comb begin
    issue  = (st_q == ST_ISSUE) && !hold;
    b_last = (b_q == (LOGN-1)'(NH - 1));
    s_last = (s_q == STAGE_W'(LOGN - 1));
    w_last = v_q[BF_LAT-1] & l_q[BF_LAT-1];
  end

  // Delay line shifts every cycle; hold only gates what enters it.
  always_comb begin
    v_d     = '0;
    l_d     = '0;
    wa_d    = '0;
    wb_d    = '0;
    v_d[0]  = issue;
    l_d[0]  = issue & b_last;
    wa_d[0] = issue ? ra : '0;
    wb_d[0] = issue ? rb : '0;
    for (int i = 1; i < BF_LAT; i++) begin
      v_d[i]  = v_q[i-1];
      l_d[i]  = l_q[i-1];
      wa_d[i] = wa_q[i-1];
      wb_d[i] = wb_q[i-1];
    end
  end

  // Stage sequencing; DRAIN exits on the stage's last write-back.
  always_comb begin
    st_d = st_q;
    s_d  = s_q;
    b_d  = b_q;
    unique case (st_q)
      ST_IDLE: begin
        if (start) begin
          st_d = ST_ISSUE;
          s_d  = '0;
          b_d  = '0;
        end
      end
      ST_ISSUE: begin
        if (!hold) begin
          b_d = b_q + (LOGN-1)'(1);
          if (b_last) begin
            st_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_last) begin
          if (s_last) begin
            st_d = ST_DONE;
          end else begin
            st_d = ST_ISSUE;
            s_d  = s_q + STAGE_W'(1);
            b_d  = '0;
          end
        end
      end
      ST_DONE: begin
        st_d = ST_IDLE;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and delay line; reset discards in-flight writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= ST_IDLE;
      s_q  <= '0;
      b_q  <= '0;
      v_q  <= '0;
      l_q  <= '0;
      wa_q <= '0;
      wb_q <= '0;
    end else begin
      st_q <= st_d;
      s_q  <= s_d;
      b_q  <= b_d;
      v_q  <= v_d;
      l_q  <= l_d;
      wa_q <= wa_d;
      wb_q <= wb_d;
    end
  end

  // Output drive; read addresses are zero when no butterfly issues.
  always_comb begin
    busy      = (st_q != ST_IDLE);
    done      = (st_q == ST_DONE);
    stage     = s_q;
    rd_en     = issue;
    rd_addr_a = issue ? ra : '0;
    rd_addr_b = issue ? rb : '0;
    tw_idx    = issue ? tw : '0;
    wr_en     = v_q[BF_LAT-1];
    wr_addr_a = wa_q[BF_LAT-1];
    wr_addr_b = wb_q[BF_LAT-1];
  end

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// tb_ntt_stage_ctrl: scoreboard bench for ntt_stage_ctrl.
// Small (LOGN=3, BF_LAT=2) and default (LOGN=8, BF_LAT=4) instances.
module tb_ntt_stage_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Small instance
  logic       r0, st0, h0;
  logic       busy0, done0, rd0, wr0;
  logic [3:0] stg0;
  logic [2:0] ra0, rb0, wa0, wb0;
  logic [1:0] tw0;

  ntt_stage_ctrl #(.LOGN(3), .BF_LAT(2), .STAGE_W(4)) u_small (
    .clk(clk), .rst(r0), .start(st0), .hold(h0),
    .busy(busy0), .done(done0), .stage(stg0),
    .rd_en(rd0), .rd_addr_a(ra0), .rd_addr_b(rb0),
    .tw_idx(tw0), .wr_en(wr0),
    .wr_addr_a(wa0), .wr_addr_b(wb0)
  );

  // Default instance
  logic       r1, st1, h1;
  logic       busy1, done1, rd1, wr1;
  logic [3:0] stg1;
  logic [7:0] ra1, rb1, wa1, wb1;
  logic [6:0] tw1;

  ntt_stage_ctrl #(.LOGN(8), .BF_LAT(4), .STAGE_W(4)) u_big (
    .clk(clk), .rst(r1), .start(st1), .hold(h1),
    .busy(busy1), .done(done1), .stage(stg1),
    .rd_en(rd1), .rd_addr_a(ra1), .rd_addr_b(rb1),
    .tw_idx(tw1), .wr_en(wr1),
    .wr_addr_a(wa1), .wr_addr_b(wb1)
  );

  int sel = 0;
  int m_busy, m_done, m_rd, m_wr, m_stage;
  int m_a, m_b, m_tw, m_wa, m_wb;

  always_comb begin
    if (sel == 0) begin
      m_busy = int'(busy0); m_done = int'(done0);
      m_rd = int'(rd0);     m_wr = int'(wr0);
      m_stage = int'(stg0);
      m_a = int'(ra0);  m_b = int'(rb0);
      m_tw = int'(tw0);
      m_wa = int'(wa0); m_wb = int'(wb0);
    end else begin
      m_busy = int'(busy1); m_done = int'(done1);
      m_rd = int'(rd1);     m_wr = int'(wr1);
      m_stage = int'(stg1);
      m_a = int'(ra1);  m_b = int'(rb1);
      m_tw = int'(tw1);
      m_wa = int'(wa1); m_wb = int'(wb1);
    end
  end

  typedef struct {
    int cyc;
    int st;
    int a;
    int b;
    int tw;
  } ev_t;

  ev_t rq[$];
  ev_t wq[$];

  bit hold_sch[0:4095];
  bit xtra_sch[0:4095];
  int cnt[0:7][0:255];

  int n_cmp = 0;
  int n_bad = 0;
  int t0 = 0;
  int exp_done = -1;
  int exp_end = 0;
  int rst_at = -1;
  int done_rel = -1;
  bit mon_on = 1'b0;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)",
               name, act, exp, cyc - t0);
    end
  endtask

  // Reference: enumerate each stage's pairs block by block,
  // placing reads on cycles not held, then BF_LAT to write-back.
  task automatic build(int logn, int lat);
    int n;
    int t;
    int last;
    int half;
    ev_t e;
    n = 1 << logn;
    t = 1;
    last = 0;
    rq.delete();
    wq.delete();
    for (int s = 0; s < logn; s++) begin
      half = 1 << s;
      for (int j = 0; j < n; j += 2 * half) begin
        for (int k = 0; k < half; k++) begin
          while (hold_sch[t]) t++;
          e.cyc = t; e.st = s;
          e.a = j + k; e.b = j + k + half;
          e.tw = k * (n / (2 * half));
          if (rst_at < 0 || t <= rst_at) rq.push_back(e);
          e.cyc = t + lat;
          if (rst_at < 0 || t + lat <= rst_at)
            wq.push_back(e);
          last = t;
          t++;
        end
      end
      t = last + lat + 1;
    end
    exp_done = (rst_at < 0) ? last + lat + 1 : -1;
    exp_end  = (rst_at < 0) ? exp_done : rst_at;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a transfer.
  always @(negedge clk) begin
    int rel;
    ev_t e;
    if (mon_on) begin
      rel = cyc - t0;
      chk("busy", m_busy, int'(rel >= 1 && rel <= exp_end));
      chk("done", m_done, int'(rel == exp_done));
      if (m_done != 0) done_rel = rel;
      if (rst_at >= 0 && rel == rst_at + 1) begin
        chk("post_rst_outs",
            m_busy + m_done + m_rd + m_wr + m_stage +
            m_a + m_b + m_tw + m_wa + m_wb, 0);
      end
      if (m_rd != 0) begin
        if (m_stage < 8 && m_a < 256 && m_b < 256) begin
          cnt[m_stage][m_a]++;
          cnt[m_stage][m_b]++;
        end
        if (rq.size() == 0) begin
          chk("rd_unexpected", m_rd, 0);
        end else begin
          e = rq.pop_front();
          chk("rd_cycle", rel, e.cyc);
          chk("rd_stage", m_stage, e.st);
          chk("rd_addr_a", m_a, e.a);
          chk("rd_addr_b", m_b, e.b);
          chk("tw_idx", m_tw, e.tw);
        end
      end
      if (m_wr != 0) begin
        if (wq.size() == 0) begin
          chk("wr_unexpected", m_wr, 0);
        end else begin
          e = wq.pop_front();
          chk("wr_cycle", rel, e.cyc);
          chk("wr_addr_a", m_wa, e.a);
          chk("wr_addr_b", m_wb, e.b);
        end
      end
    end
  end

  task automatic drive(int s, bit rv, bit sv, bit hv);
    if (s == 0) begin
      r0 = rv; st0 = sv; h0 = hv;
    end else begin
      r1 = rv; st1 = sv; h1 = hv;
    end
  endtask

  task automatic clear_sch();
    for (int i = 0; i < 4096; i++) begin
      hold_sch[i] = 1'b0;
      xtra_sch[i] = 1'b0;
    end
  endtask

  task automatic run(int s, int logn, int lat, int ra);
    int n;
    int ones;
    n = 1 << logn;
    sel = s;
    rst_at = ra;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 256; j++)
        cnt[i][j] = 0;
    build(logn, lat);
    done_rel = -1;
    t0 = cyc;
    mon_on = 1'b1;
    for (int rel = 0; rel <= exp_end + 6; rel++) begin
      drive(s, rel == ra, rel == 0 || xtra_sch[rel],
            hold_sch[rel]);
      @(posedge clk);
      #1;
    end
    mon_on = 1'b0;
    drive(s, 1'b0, 1'b0, 1'b0);
    chk("rd_queue_left", rq.size(), 0);
    chk("wr_queue_left", wq.size(), 0);
    chk("done_seen_at", done_rel, exp_done);
    if (ra < 0) begin
      chk("final_stage", m_stage, logn - 1);
      for (int st = 0; st < logn; st++) begin
        ones = 0;
        for (int a = 0; a < n; a++)
          if (cnt[st][a] == 1) ones++;
        chk("once_per_stage", ones, n);
      end
    end else begin
      chk("stage_after_rst", m_stage, 0);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      chk("reset_outs",
          m_busy + m_done + m_rd + m_wr + m_stage +
          m_a + m_b + m_tw + m_wa + m_wb, 0);
    end
    @(posedge clk);
    #1;

    clear_sch();
    run(0, 3, 2, -1);
    chk("basic_done_cycle", done_rel, 19);

    clear_sch();
    hold_sch[5] = 1'b1;
    hold_sch[6] = 1'b1;
    hold_sch[8] = 1'b1;
    hold_sch[9] = 1'b1;
    hold_sch[10] = 1'b1;
    run(0, 3, 2, -1);
    chk("hold_done_cycle", done_rel, 22);

    clear_sch();
    xtra_sch[5] = 1'b1;
    xtra_sch[12] = 1'b1;
    run(0, 3, 2, -1);
    chk("busy_start_done", done_rel, 19);

    clear_sch();
    run(0, 3, 2, 9);
    clear_sch();
    run(0, 3, 2, -1);
    chk("rerun_done_cycle", done_rel, 19);

    clear_sch();
    run(1, 8, 4, -1);
    chk("default_done_cycle", done_rel, 1057);

    clear_sch();
    for (int i = 1; i < 2000; i++)
      hold_sch[i] = ($urandom_range(0, 7) == 0);
    run(1, 8, 4, -1);

    clear_sch();
    for (int i = 1; i < 40; i++)
      hold_sch[i] = ($urandom_range(0, 2) == 0);
    run(0, 3, 2, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
